block_ula_seq: RTL and testbench
================================

# block_ula_seq

Parametrised, sequential successor to the stack machine's ALU-ops block. It accepts a pair of operands and an opcode through a start/done handshake. Single-cycle ops finish in one cycle; multiply and shifts run as multi-cycle iterative datapaths. It keeps a per-stack-slot comparison flag memory indexed by the top-of-stack pointer and a width-correct overflow flag. It sits between the operand stack and the result write-back path of the core.

## Interface
- DATA_WIDTH, 8, operand/result width (≥2)
- ADDR_WIDTH, 12, stack pointer width; flag memory depth 2^ADDR_WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low; one clock, all state on clk
- OP_L_IN  in  DATA_WIDTH  left operand (top-1)
- OP_R_IN  in  DATA_WIDTH  right operand (top)
- SEL_ULA  in  4  opcode, sampled with START
- TOS_IN  in  ADDR_WIDTH  top-of-stack pointer, sampled with START; also read address
- START  in  1  request; accepted only when BUSY=0
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle completion pulse
- ULA_OUT  out  DATA_WIDTH  registered result
- OVERFLOW_OUT  out  1  registered overflow flag
- STACK_COMP_OUT  out  1  flag memory content at TOS_IN, combinational read

## Operation
- Opcodes: 0 ADD L+R; 1 SUB L−R; 2 MUL L×R; 3 LSHIFT L<<R; 4 RSHIFT L>>R; 5 OR; 6 AND; 7 XOR; 8 NOT ~R; 9 EQ; 10 NE; 11 GT; 12 LT; 13 GE; 14 LE (all unsigned, L vs R); 15 reserved.
- Accept: rising edge with START=1, BUSY=0 latches L, R, SEL_ULA, TOS_IN. START while BUSY=1 is ignored, with no queueing.
- FSM: IDLE → MUL (op 2) or SHIFT (ops 3/4 with shift count > 0) → IDLE. All other ops complete at the accept edge.
- MUL: shift-add over a 2·DATA_WIDTH product register, one bit of R per cycle, DATA_WIDTH iterations. ULA_OUT = low half. Overflow = (high half ≠ 0).
- SHIFT: count = min(R, DATA_WIDTH); one bit per cycle. LSHIFT overflow = any 1 shifted out. RSHIFT overflow = 0. Count 0 is single-cycle: result = L, overflow 0.
- ADD overflow = carry out. SUB overflow = borrow (L<R), result wraps modulo 2^DATA_WIDTH.
- OVERFLOW_OUT is updated only by ops 0–4 and held otherwise.
- Compare ops (9–14): ULA_OUT = zero-extended result bit. The flag memory at the latched TOS is written with the result bit at the completion edge.
- Op 15: ULA_OUT = 0, no flag write, OVERFLOW_OUT held, DONE still pulses.
- Flag memory is not reset. Its content is undefined until written.

## Timing
- Reset values: ULA_OUT=0, OVERFLOW_OUT=0, BUSY=0, DONE=0, FSM=IDLE. Any in-flight op is aborted with no flag write.
- Single-cycle ops: accept edge t; DONE=1 and results valid during cycle t+1. BUSY stays 0.
- MUL: BUSY=1 from t+1 to t+DATA_WIDTH. DONE and result in cycle t+DATA_WIDTH+1.
- SHIFT with count c>0: BUSY=1 for c cycles. DONE in cycle t+c+1.
- BUSY falls in the same cycle DONE rises. A START during that DONE cycle is accepted, giving back-to-back operation.
- ULA_OUT holds its value between completions.
- STACK_COMP_OUT reflects a flag write from the cycle after the write edge.

## Structure
- Shared package `ula_pkg`: opcode localparams (ULA_ADD … ULA_LE, ULA_RSV), FSM state enum {S_IDLE, S_MUL, S_SHIFT}.
- Sub-module `ula_seq_mult`: iterative multiplier with start/done, product and overflow outputs.
- Flag memory: the existing STACK_MEMORY instantiated with DATA_WIDTH_MEM=1.

## Test plan
- ADD L=200, R=100, START at t → DONE at t+1, ULA_OUT=44, OVERFLOW_OUT=1, BUSY never high.
- SUB L=5, R=7 → ULA_OUT=254, OVERFLOW_OUT=1. A following AND 0xF0&0x3C → 0x30 with OVERFLOW_OUT still 1.
- MUL 16×17 → BUSY 8 cycles, DONE at t+9, ULA_OUT=16, OVERFLOW_OUT=1. MUL 15×17 → 255, overflow 0. START pulsed mid-MUL is ignored.
- LSHIFT 0x81<<1 → DONE at t+2, 0x02, overflow 1. RSHIFT 0x80>>200 → count saturates to 8, DONE at t+9, 0x00.
- LT L=3, R=9, TOS=5 → ULA_OUT=1, flag[5]=1, STACK_COMP_OUT=1 when TOS_IN=5. EQ 4,4 at TOS=6 issued back-to-back on the DONE cycle → flag[6]=1, flag[5] unchanged.
- rst_n low at cycle 4 of a MUL → BUSY=0, DONE=0, ULA_OUT=0, OVERFLOW_OUT=0 immediately. After release, a new ADD 1+1 completes normally with 2.

Source files
------------

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared opcode constants and FSM state type for block_ula_seq
// Purpose: opcode encodings (ULA_ADD .. ULA_LE, ULA_RSV) and the control FSM
//          state enum, imported by the ALU top, its interface and the bench.
// Ports:   none (package)
package ula_pkg;

  localparam logic [3:0] ULA_ADD    = 4'd0;
  localparam logic [3:0] ULA_SUB    = 4'd1;
  localparam logic [3:0] ULA_MUL    = 4'd2;
  localparam logic [3:0] ULA_LSHIFT = 4'd3;
  localparam logic [3:0] ULA_RSHIFT = 4'd4;
  localparam logic [3:0] ULA_OR     = 4'd5;
  localparam logic [3:0] ULA_AND    = 4'd6;
  localparam logic [3:0] ULA_XOR    = 4'd7;
  localparam logic [3:0] ULA_NOT    = 4'd8;
  localparam logic [3:0] ULA_EQ     = 4'd9;
  localparam logic [3:0] ULA_NE     = 4'd10;
  localparam logic [3:0] ULA_GT     = 4'd11;
  localparam logic [3:0] ULA_LT     = 4'd12;
  localparam logic [3:0] ULA_GE     = 4'd13;
  localparam logic [3:0] ULA_LE     = 4'd14;
  localparam logic [3:0] ULA_RSV    = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_SHIFT
  } ula_state_t;

endpackage

// File: rtl/block_ula_seq_if.sv
// rtl/block_ula_seq_if.sv - operand/opcode request and result bundle of block_ula_seq
// Purpose: groups the start/done handshake, operands and results.
// Ports:   master drives OP_L_IN, OP_R_IN, SEL_ULA, TOS_IN, START and reads
//          BUSY, DONE, ULA_OUT, OVERFLOW_OUT, STACK_COMP_OUT; slave is the ALU.
interface block_ula_seq_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);

  logic [DATA_WIDTH-1:0] OP_L_IN;
  logic [DATA_WIDTH-1:0] OP_R_IN;
  logic [3:0]            SEL_ULA;
  logic [ADDR_WIDTH-1:0] TOS_IN;
  logic                  START;
  logic                  BUSY;
  logic                  DONE;
  logic [DATA_WIDTH-1:0] ULA_OUT;
  logic                  OVERFLOW_OUT;
  logic                  STACK_COMP_OUT;

  modport master (
    output OP_L_IN, OP_R_IN, SEL_ULA, TOS_IN, START,
    input  BUSY, DONE, ULA_OUT, OVERFLOW_OUT, STACK_COMP_OUT
  );

  modport slave (
    input  OP_L_IN, OP_R_IN, SEL_ULA, TOS_IN, START,
    output BUSY, DONE, ULA_OUT, OVERFLOW_OUT, STACK_COMP_OUT
  );

endinterface

// File: rtl/STACK_MEMORY.sv
// rtl/STACK_MEMORY.sv - per-stack-slot memory, synchronous write, combinational read
// Purpose: 2^ADDR_WIDTH words of DATA_WIDTH_MEM bits; contents are not reset.
// Ports:   clk, we, waddr, wdata (write side); raddr -> rdata (async read)
module STACK_MEMORY #(
  parameter int DATA_WIDTH_MEM = 8,
  parameter int ADDR_WIDTH     = 12
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [DATA_WIDTH_MEM-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]     raddr,
  output logic [DATA_WIDTH_MEM-1:0] rdata
);

  logic [DATA_WIDTH_MEM-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ula_seq_mult.sv
// rtl/ula_seq_mult.sv - iterative shift-add multiplier, one multiplier bit per cycle
// Purpose: unsigned a*b over a 2*DATA_WIDTH accumulator.
// Ports:   clk, rst_n (async active-low), start, a, b in;
//          done (one-cycle pulse), product (low half), overflow (high half != 0) out
module ula_seq_mult #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product,
  output logic                  overflow
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CW-1:0]           remaining;
  logic                    run;

  // Bit 0 of b is folded into the start edge so that the last of the
  // DATA_WIDTH iterations lands one edge before the caller latches the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      remaining <= '0;
      run       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc       <= b[0] ? {{DATA_WIDTH{1'b0}}, a} : '0;
        mcand     <= {{(DATA_WIDTH-1){1'b0}}, a, 1'b0};
        mplier    <= b >> 1;
        remaining <= CW'(DATA_WIDTH - 1);
        run       <= 1'b1;
      end else if (run) begin
        acc       <= acc + (mplier[0] ? mcand : '0);
        mcand     <= mcand << 1;
        mplier    <= mplier >> 1;
        remaining <= remaining - CW'(1);
        if (remaining == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product  = acc[DATA_WIDTH-1:0];
  assign overflow = |acc[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/block_ula_seq.sv
// rtl/block_ula_seq.sv - sequential stack-machine ALU with per-slot compare flags
// Purpose: single-cycle logic/arith/compare ops, iterative MUL and shifts,
//          overflow flag, and a 1-bit flag memory addressed by top-of-stack.
// Ports:   clk, rst_n (async active-low); bus (block_ula_seq_if.slave):
//          OP_L_IN, OP_R_IN, SEL_ULA, TOS_IN, START in;
//          BUSY, DONE, ULA_OUT, OVERFLOW_OUT, STACK_COMP_OUT out
module block_ula_seq
  import ula_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  block_ula_seq_if.slave  bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

  ula_state_t state, state_nxt;

  logic                  busy, accept, mul_start, is_shift, is_cmp, cmp_bit, flag_we;
  logic [CW-1:0]         shift_cnt_in, shift_cnt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt, result;
  logic                  shift_left, shift_ovf, shift_ovf_nxt, overflow, done;
  logic [DATA_WIDTH:0]   add_sum;
  logic                  mul_done, mul_ovf;
  logic [DATA_WIDTH-1:0] mul_prod;

  assign add_sum  = {1'b0, bus.OP_L_IN} + {1'b0, bus.OP_R_IN};
  assign is_shift = (bus.SEL_ULA == ULA_LSHIFT) || (bus.SEL_ULA == ULA_RSHIFT);

  // Shift count saturates at DATA_WIDTH: anything larger shifts everything out.
  always_comb begin
    if (((bus.OP_R_IN >> CW) != '0) || (bus.OP_R_IN[CW-1:0] >= CNT_MAX)) begin
      shift_cnt_in = CNT_MAX;
    end else begin
      shift_cnt_in = bus.OP_R_IN[CW-1:0];
    end
  end

  always_comb begin
    cmp_bit = 1'b0;
    is_cmp  = 1'b1;
    case (bus.SEL_ULA)
      ULA_EQ:  cmp_bit = (bus.OP_L_IN == bus.OP_R_IN);
      ULA_NE:  cmp_bit = (bus.OP_L_IN != bus.OP_R_IN);
      ULA_GT:  cmp_bit = (bus.OP_L_IN >  bus.OP_R_IN);
      ULA_LT:  cmp_bit = (bus.OP_L_IN <  bus.OP_R_IN);
      ULA_GE:  cmp_bit = (bus.OP_L_IN >= bus.OP_R_IN);
      ULA_LE:  cmp_bit = (bus.OP_L_IN <= bus.OP_R_IN);
      default: is_cmp  = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.START) begin
          if (bus.SEL_ULA == ULA_MUL) begin
            state_nxt = S_MUL;
          end else if (is_shift && (shift_cnt_in != '0)) begin
            state_nxt = S_SHIFT;
          end
        end
      end
      S_MUL:   if (mul_done) state_nxt = S_IDLE;
      S_SHIFT: if (shift_cnt == CW'(1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; the flag write is held off while reset is asserted so a
  // START seen during reset cannot corrupt the flag memory.
  always_comb begin
    busy      = (state != S_IDLE);
    accept    = (state == S_IDLE) && bus.START;
    mul_start = accept && (bus.SEL_ULA == ULA_MUL);
    flag_we   = accept && is_cmp && rst_n;
  end

  assign shift_nxt     = shift_left ? (shift_reg << 1) : (shift_reg >> 1);
  assign shift_ovf_nxt = shift_ovf | (shift_left & shift_reg[DATA_WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      shift_reg  <= '0;
      shift_cnt  <= '0;
      shift_left <= 1'b0;
      shift_ovf  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (bus.SEL_ULA)
          ULA_ADD: begin
            {overflow, result} <= add_sum;
            done               <= 1'b1;
          end
          ULA_SUB: begin
            result   <= bus.OP_L_IN - bus.OP_R_IN;
            overflow <= (bus.OP_L_IN < bus.OP_R_IN);
            done     <= 1'b1;
          end
          ULA_MUL: begin
          end
          ULA_LSHIFT, ULA_RSHIFT: begin
            if (shift_cnt_in == '0) begin
              result   <= bus.OP_L_IN;
              overflow <= 1'b0;
              done     <= 1'b1;
            end else begin
              shift_reg  <= bus.OP_L_IN;
              shift_cnt  <= shift_cnt_in;
              shift_left <= (bus.SEL_ULA == ULA_LSHIFT);
              shift_ovf  <= 1'b0;
            end
          end
          ULA_OR:  begin result <= bus.OP_L_IN | bus.OP_R_IN; done <= 1'b1; end
          ULA_AND: begin result <= bus.OP_L_IN & bus.OP_R_IN; done <= 1'b1; end
          ULA_XOR: begin result <= bus.OP_L_IN ^ bus.OP_R_IN; done <= 1'b1; end
          ULA_NOT: begin result <= ~bus.OP_R_IN;              done <= 1'b1; end
          ULA_RSV: begin result <= '0;                        done <= 1'b1; end
          default: begin
            result <= {{(DATA_WIDTH-1){1'b0}}, cmp_bit};
            done   <= 1'b1;
          end
        endcase
      end else if ((state == S_MUL) && mul_done) begin
        result   <= mul_prod;
        overflow <= mul_ovf;
        done     <= 1'b1;
      end else if (state == S_SHIFT) begin
        shift_reg <= shift_nxt;
        shift_ovf <= shift_ovf_nxt;
        shift_cnt <= shift_cnt - CW'(1);
        if (shift_cnt == CW'(1)) begin
          result   <= shift_nxt;
          overflow <= shift_ovf_nxt;
          done     <= 1'b1;
        end
      end
    end
  end

  ula_seq_mult #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mul_start),
    .a        (bus.OP_L_IN),
    .b        (bus.OP_R_IN),
    .done     (mul_done),
    .product  (mul_prod),
    .overflow (mul_ovf)
  );

  STACK_MEMORY #(
    .DATA_WIDTH_MEM (1),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_flags (
    .clk   (clk),
    .we    (flag_we),
    .waddr (bus.TOS_IN),
    .wdata (cmp_bit),
    .raddr (bus.TOS_IN),
    .rdata (bus.STACK_COMP_OUT)
  );

  assign bus.BUSY         = busy;
  assign bus.DONE         = done;
  assign bus.ULA_OUT      = result;
  assign bus.OVERFLOW_OUT = overflow;

endmodule

// File: tb/tb_block_ula_seq.sv
// tb/tb_block_ula_seq.sv - scoreboard bench for block_ula_seq
module tb_block_ula_seq;
  import ula_pkg::*;

  localparam int DW = 8;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  block_ula_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  block_ula_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          ovf;
    int            edge_n;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   nc  = 0;
  int   nf  = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse retires the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.DONE === 1'b1) begin
      if (sb.size() == 0) begin
        nc++;
        nf++;
        $display("FAIL unexpected_done: got DONE=1 at cycle %0d expected no completion", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, 32'(bus.ULA_OUT), 32'(e.res));
        check({e.name, "_ovf"}, 32'(bus.OVERFLOW_OUT), 32'(e.ovf));
        check({e.name, "_done_cycle"}, cyc, e.edge_n);
      end
    end
  end

  // Drive a request at the current negedge; it is accepted at the next edge.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input logic [AW-1:0] tos, input logic [DW-1:0] er, input logic eo,
                       input int lat, input string name);
    exp_t e;
    bus.SEL_ULA = op;
    bus.OP_L_IN = l;
    bus.OP_R_IN = r;
    bus.TOS_IN  = tos;
    bus.START   = 1'b1;
    e.res    = er;
    e.ovf    = eo;
    e.edge_n = cyc + 1 + lat;
    e.name   = name;
    sb.push_back(e);
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.BUSY !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      nc++;
      nf++;
      $display("FAIL busy_timeout: got BUSY=%0b after %0d cycles expected 0", bus.BUSY, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    bus.START   = 1'b0;
    bus.SEL_ULA = 4'd0;
    bus.OP_L_IN = '0;
    bus.OP_R_IN = '0;
    bus.TOS_IN  = '0;
    repeat (3) @(negedge clk);
    check("rst_ula_out", 32'(bus.ULA_OUT), 0);
    check("rst_ovf", 32'(bus.OVERFLOW_OUT), 0);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_done", 32'(bus.DONE), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(ULA_ADD, 8'd200, 8'd100, '0, 8'd44, 1'b1, 0, "add_200_100");
    check("add_busy_low", 32'(bus.BUSY), 0);
    issue(ULA_SUB, 8'd5, 8'd7, '0, 8'd254, 1'b1, 0, "sub_5_7");
    issue(ULA_AND, 8'hF0, 8'h3C, '0, 8'h30, 1'b1, 0, "and_f0_3c");

    issue(ULA_MUL, 8'd16, 8'd17, '0, 8'd16, 1'b1, 8, "mul_16_17");
    check("mul_busy_high", 32'(bus.BUSY), 1);
    @(negedge clk);
    bus.SEL_ULA = ULA_ADD;
    bus.OP_L_IN = 8'd1;
    bus.OP_R_IN = 8'd1;
    bus.START   = 1'b1;
    @(negedge clk);
    bus.START   = 1'b0;
    wait_idle();
    issue(ULA_MUL, 8'd15, 8'd17, '0, 8'd255, 1'b0, 8, "mul_15_17");
    wait_idle();

    issue(ULA_LSHIFT, 8'h81, 8'd1, '0, 8'h02, 1'b1, 1, "lsh_81_1");
    wait_idle();
    issue(ULA_LSHIFT, 8'h5A, 8'd0, '0, 8'h5A, 1'b0, 0, "lsh_5a_0");
    issue(ULA_RSHIFT, 8'h80, 8'd200, '0, 8'h00, 1'b0, 8, "rsh_80_200");
    wait_idle();

    issue(ULA_OR, 8'h0F, 8'h30, '0, 8'h3F, 1'b0, 0, "or_0f_30");
    issue(ULA_XOR, 8'hFF, 8'h0F, '0, 8'hF0, 1'b0, 0, "xor_ff_0f");
    issue(ULA_NOT, 8'h00, 8'h0F, '0, 8'hF0, 1'b0, 0, "not_0f");

    issue(ULA_LT, 8'd3, 8'd9, 12'd5, 8'd1, 1'b0, 0, "lt_3_9");
    issue(ULA_EQ, 8'd4, 8'd4, 12'd6, 8'd1, 1'b0, 0, "eq_4_4");
    bus.TOS_IN = 12'd5;
    #1 check("flag5_after_lt", 32'(bus.STACK_COMP_OUT), 1);
    bus.TOS_IN = 12'd6;
    #1 check("flag6_after_eq", 32'(bus.STACK_COMP_OUT), 1);
    issue(ULA_GT, 8'd3, 8'd9, 12'd7, 8'd0, 1'b0, 0, "gt_3_9");
    issue(ULA_GE, 8'd2, 8'd9, 12'd5, 8'd0, 1'b0, 0, "ge_2_9");
    issue(ULA_LE, 8'd9, 8'd9, 12'd8, 8'd1, 1'b0, 0, "le_9_9");
    bus.TOS_IN = 12'd7;
    #1 check("flag7_after_gt", 32'(bus.STACK_COMP_OUT), 0);
    bus.TOS_IN = 12'd5;
    #1 check("flag5_after_ge", 32'(bus.STACK_COMP_OUT), 0);
    bus.TOS_IN = 12'd6;
    #1 check("flag6_kept", 32'(bus.STACK_COMP_OUT), 1);
    bus.TOS_IN = 12'd8;
    #1 check("flag8_after_le", 32'(bus.STACK_COMP_OUT), 1);

    issue(ULA_RSV, 8'h12, 8'h34, 12'd8, 8'd0, 1'b0, 0, "rsv");
    check("flag8_after_rsv", 32'(bus.STACK_COMP_OUT), 1);

    issue(ULA_ADD, 8'd200, 8'd100, '0, 8'd44, 1'b1, 0, "add_pre_abort");
    bus.SEL_ULA = ULA_MUL;
    bus.OP_L_IN = 8'd200;
    bus.OP_R_IN = 8'd3;
    bus.START   = 1'b1;
    @(negedge clk);
    bus.START   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.BUSY), 0);
    check("abort_done", 32'(bus.DONE), 0);
    check("abort_ula_out", 32'(bus.ULA_OUT), 0);
    check("abort_ovf", 32'(bus.OVERFLOW_OUT), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(ULA_ADD, 8'd1, 8'd1, '0, 8'd2, 1'b0, 0, "add_after_reset");

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
